// File: rtl/inert_sensor_model.sv
// SPI-slave inertial sensor model: register map, periodic synthetic samples
// and a level new-data interrupt cleared by reading the last data byte.
module inert_sensor_model #(
  parameter int          SAMPLE_PERIOD = 1024,
  parameter logic [7:0]  WHO_AM_I_VAL  = 8'h6A
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO,
  output logic INT
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(SAMPLE_PERIOD - 1);

  logic r_ss_s1, r_ss_s2, r_ss_s3;
  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_mosi_s1, r_mosi_s2;

  logic [15:0]   r_rx;
  logic [4:0]    r_cnt;
  logic [7:0]    r_tx;
  logic [7:0]    r_int1;
  logic [7:0]    r_ctrl1;
  logic [7:0]    r_ctrl2;
  logic [7:0]    r_data [12];
  logic [7:0]    r_idx;
  logic [TW-1:0] r_timer;
  logic          r_pend;
  logic          r_int;

  logic       w_ss_low, w_ss_fall, w_ss_rise;
  logic       w_sclk_rise, w_sclk_fall;
  logic       w_en, w_due, w_apply;
  logic       w_wr, w_clr;
  logic [6:0] w_raddr, w_waddr;
  logic [3:0] w_didx;
  logic [7:0] w_rd, w_idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_ss_s3   <= 1'b1;
      r_sclk_s1 <= 1'b1;
      r_sclk_s2 <= 1'b1;
      r_sclk_s3 <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_ss_s1   <= SS_n;
      r_ss_s2   <= r_ss_s1;
      r_ss_s3   <= r_ss_s2;
      r_sclk_s1 <= SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_mosi_s1 <= MOSI;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_ss_low    = ~r_ss_s2;
  assign w_ss_fall   = r_ss_s3 & ~r_ss_s2;
  assign w_ss_rise   = ~r_ss_s3 & r_ss_s2;
  assign w_sclk_rise = ~r_sclk_s3 & r_sclk_s2;
  assign w_sclk_fall = r_sclk_s3 & ~r_sclk_s2;

  assign w_raddr   = r_rx[6:0];
  assign w_waddr   = r_rx[14:8];
  assign w_didx    = w_raddr[3:0] - 4'd2;
  assign w_idx_nxt = r_idx + 8'd1;

  always_comb begin
    w_rd = 8'h00;
    unique case (1'b1)
      (w_raddr == 7'h0F): w_rd = WHO_AM_I_VAL;
      (w_raddr == 7'h0D): w_rd = r_int1;
      (w_raddr == 7'h10): w_rd = r_ctrl1;
      (w_raddr == 7'h11): w_rd = r_ctrl2;
      (w_raddr >= 7'h22 && w_raddr <= 7'h2D):
        w_rd = r_data[w_didx];
      default: w_rd = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx  <= '0;
      r_cnt <= '0;
      r_tx  <= '0;
    end else if (w_ss_fall) begin
      r_rx  <= '0;
      r_cnt <= '0;
      r_tx  <= '0;
    end else begin
      if (w_sclk_rise && w_ss_low) begin
        r_rx <= {r_rx[14:0], r_mosi_s2};
        if (r_cnt != 5'd16)
          r_cnt <= r_cnt + 5'd1;
      end
      if (w_sclk_fall && w_ss_low) begin
        if (r_cnt == 5'd8 && r_rx[7])
          r_tx <= w_rd;
        else
          r_tx <= {r_tx[6:0], 1'b0};
      end
    end
  end

  assign MISO = w_ss_low & r_tx[7];
  assign INT  = r_int;

  assign w_wr = w_ss_rise & (r_cnt == 5'd16) & ~r_rx[15];
  assign w_clr = w_ss_rise & (r_cnt == 5'd16) & r_rx[15]
               & (w_waddr == 7'h2D);

  assign w_en    = |r_int1[1:0];
  assign w_due   = w_en & (r_timer == LAST);
  // A sample that lands inside a frame waits for SS_n to go high.
  assign w_apply = ~w_ss_low & (w_due | r_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int1  <= '0;
      r_ctrl1 <= '0;
      r_ctrl2 <= '0;
      r_idx   <= '0;
      r_timer <= '0;
      r_pend  <= 1'b0;
      r_int   <= 1'b0;
      for (int k = 0; k < 12; k++)
        r_data[k] <= '0;
    end else begin
      if (!w_en || r_timer == LAST)
        r_timer <= '0;
      else
        r_timer <= r_timer + 1'b1;

      if (w_apply)
        r_pend <= 1'b0;
      else if (w_due)
        r_pend <= 1'b1;

      if (w_apply) begin
        r_idx <= w_idx_nxt;
        for (int k = 0; k < 6; k++) begin
          r_data[2*k]   <= {4'h0, 4'(k)};
          r_data[2*k+1] <= w_idx_nxt;
        end
      end

      if (w_apply)
        r_int <= 1'b1;
      else if (w_clr)
        r_int <= 1'b0;

      if (w_wr) begin
        unique case (1'b1)
          (w_waddr == 7'h0D): r_int1  <= r_rx[7:0];
          (w_waddr == 7'h10): r_ctrl1 <= r_rx[7:0];
          (w_waddr == 7'h11): r_ctrl2 <= r_rx[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inert_sensor_model.sv
// Directed/random SPI bench for inert_sensor_model with a register-map
// reference model.
module tb_inert_sensor_model;

  logic clk = 1'b0;
  logic rst_n, SS_n, SCLK, MOSI;
  logic MISO, INT;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  logic [7:0] m_reg [128];
  logic [7:0] m_idx;
  logic       m_int;
  logic       m_sampled;

  inert_sensor_model dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (SS_n),
    .SCLK  (SCLK),
    .MOSI  (MOSI),
    .MISO  (MISO),
    .INT   (INT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [6:0] a);
    logic [6:0] off;
    if (a == 7'h0F) return 8'h6A;
    if (a == 7'h0D || a == 7'h10 || a == 7'h11) return m_reg[a];
    if (a >= 7'h22 && a <= 7'h2D) begin
      if (!m_sampled) return 8'h00;
      off = a - 7'h22;
      if (off[0]) return m_idx;
      return {2'b00, off[6:1]};
    end
    return 8'h00;
  endfunction

  task automatic model_wr(input logic [6:0] a, input logic [7:0] d);
    if (a == 7'h0D || a == 7'h10 || a == 7'h11) m_reg[a] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_reg[i] = 8'h00;
    m_idx = 8'h00;
    m_int = 1'b0;
    m_sampled = 1'b0;
  endtask

  // Mode-3 master: half-period 10 clk, MISO captured on SCLK rise.
  task automatic spi(input logic [15:0] w, input int nb, input int hold,
                     input int gap, input bit keep,
                     output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk);
    SS_n = 1'b0;
    repeat (10 + hold) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      SCLK = 1'b0;
      MOSI = w[15-i];
      repeat (10) @(negedge clk);
      SCLK = 1'b1;
      if (i >= 8) rd = {rd[6:0], MISO};
      repeat (10) @(negedge clk);
    end
    if (!keep) begin
      SS_n = 1'b1;
      MOSI = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rd;
    spi({1'b0, a, d}, 16, 0, 12, 1'b0, rd);
    model_wr(a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a);
    logic [7:0] rd;
    logic [7:0] e;
    e = exp_rd(a);
    spi({1'b1, a, 8'h00}, 16, 0, 12, 1'b0, rd);
    check(tag, rd, e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    logic [6:0] tbl [7];
    logic [6:0] a;
    logic [7:0] d, rd;
    int t0;

    tbl = '{7'h10, 7'h11, 7'h0F, 7'h22, 7'h2D, 7'h0D, 7'h00};
    model_reset();
    rst_n = 1'b0;
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_int", {7'h0, INT}, 8'h00);
    check("reset_miso", {7'h0, MISO}, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    rd_chk("who_am_i", 7'h0F);
    check("who_int", {7'h0, INT}, 8'h00);

    for (int it = 0; it < 8; it++) begin
      a = tbl[$urandom_range(6)];
      if (a == 7'h00) a = 7'($urandom);
      d = 8'($urandom);
      if (a == 7'h0D) d = d & 8'hFC;
      wr(a, d);
      a = tbl[$urandom_range(6)];
      if (a == 7'h00) a = 7'($urandom);
      rd_chk("rand_rd", a);
    end
    check("rand_int", {7'h0, INT}, 8'h00);

    wr(7'h0D, 8'h02);
    t0 = cyc;
    rd_chk("int1_rd", 7'h0D);
    wait_until(t0 + 1006);
    check("int_before_period", {7'h0, INT}, 8'h00);
    wait_until(t0 + 1020);
    m_idx = 8'h01;
    m_sampled = 1'b1;
    m_int = 1'b1;
    check("int_after_period", {7'h0, INT}, 8'h01);
    wr(7'h0D, 8'h00);
    check("int_kept_on_disable", {7'h0, INT}, 8'h01);
    rd_chk("data_a2", 7'h22);
    rd_chk("data_a3", 7'h23);
    rd_chk("data_a8", 7'h28);
    check("int_other_reads", {7'h0, INT}, 8'h01);

    wr(7'h0D, 8'h01);
    spi(16'hAD00, 16, 900, 12, 1'b0, rd);
    check("pend_old_data", rd, 8'h01);
    m_idx = 8'h02;
    check("set_wins_int", {7'h0, INT}, 8'h01);
    wr(7'h0D, 8'h00);
    rd_chk("pend_new_a3", 7'h23);
    spi(16'hAD00, 12, 0, 12, 1'b0, rd);
    check("abort_read_int", {7'h0, INT}, 8'h01);
    spi(16'hAD00, 16, 0, 3, 1'b0, rd);
    check("read_2d", rd, 8'h02);
    m_int = 1'b0;
    check("int_cleared", {7'h0, INT}, 8'h00);

    wr(7'h10, 8'h00);
    spi(16'h1055, 10, 0, 12, 1'b0, rd);
    rd_chk("abort_write", 7'h10);

    wr(7'h0D, 8'h03);
    t0 = cyc;
    wait_until(t0 + 1020);
    check("int_before_rst", {7'h0, INT}, 8'h01);
    spi(16'h8F00, 10, 0, 0, 1'b1, rd);
    check("partial_rd", rd, 8'h01);
    check("miso_mid", {7'h0, MISO}, 8'h01);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_int", {7'h0, INT}, 8'h00);
    check("rst_miso", {7'h0, MISO}, 8'h00);
    SS_n = 1'b1;
    SCLK = 1'b1;
    MOSI = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk("rst_int1", 7'h0D);
    rd_chk("rst_data", 7'h23);
    t0 = cyc;
    wait_until(t0 + 2100);
    check("no_samples", {7'h0, INT}, 8'h00);
    rd_chk("still_no_data", 7'h22);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/inert_sensor_model.md
INERT_SENSOR_MODEL -- requirements
Module: inert_sensor_model

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 1024, clk cycles between new inertial samples.
REQ-002 Parameter WHO_AM_I_VAL, default 8'h6A, fixed identity byte.
REQ-003 clk  input  1  system clock; all state on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SS_n  input  1  SPI select from master, active low.
REQ-006 SCLK  input  1  SPI clock from master, idles high.
REQ-007 MOSI  input  1  SPI data in, changes on SCLK fall, sampled on SCLK rise.
REQ-008 MISO  output  1  SPI data out, changes on SCLK fall.
REQ-009 INT  output  1  new-data interrupt, active high, level.

Function
REQ-010 SS_n, SCLK and MOSI SHALL each pass through a 2-flop synchronizer; a third flop on SCLK and SS_n SHALL give rise/fall detects.
REQ-011 SCLK half-period SHALL be at least 8 clk; shorter SCLK is outside the operating range.
REQ-012 Transaction: synchronized SS_n fall clears 16-bit rx shifter, 5-bit bit_cnt, 8-bit tx shifter.
REQ-013 Each synchronized SCLK rise with SS_n low SHALL shift MOSI into rx[0] (MSB first) and increment bit_cnt, saturating at 16.
REQ-014 Frame format: bit15 = R/W (1 read, 0 write), bits14:8 = address, bits7:0 = data.
REQ-015 Read: on the first synchronized SCLK fall with bit_cnt==8 and rx[7]==1, tx SHALL load register[rx[6:0]]; each later fall SHALL shift tx left, zero fill.
REQ-016 MISO SHALL equal tx[7] while SS_n low; 0 while SS_n high.
REQ-017 Write: on synchronized SS_n rise with bit_cnt==16 and rx[15]==0, register[rx[14:8]] <= rx[7:0]; otherwise no write (aborted frame).
REQ-018 Register map: 0x0F WHO_AM_I RO =WHO_AM_I_VAL; 0x0D INT1_CTRL RW; 0x10 CTRL1_XL RW; 0x11 CTRL2_G RW; 0x22-0x2D data RO.
REQ-019 Unmapped reads return 8'h00; writes to RO or unmapped addresses ignored.
REQ-020 Sample timer SHALL count clk cycles while INT1_CTRL[1:0]!=0; at count SAMPLE_PERIOD-1 it wraps to 0 and raises sample_due; timer held at 0 otherwise.
REQ-021 On sample_due with SS_n (synchronized) high: sample_idx (8 bits, wraps 255->0) increments; data word k (k=0..5, at 0x22+2k low byte, 0x23+2k high byte) = {new sample_idx, 4'h0, k[3:0]}; INT set.
REQ-022 sample_due while SS_n low SHALL be held pending and applied on the cycle after synchronized SS_n rise.
REQ-023 INT SHALL clear on synchronized SS_n rise ending a complete read (bit_cnt==16) of address 0x2D.
REQ-024 Pending sample update and INT clear in the same cycle: set wins, INT stays 1, data updates.
REQ-025 Writing INT1_CTRL[1:0]=0 SHALL stop the timer but SHALL NOT clear INT or a pending update.
REQ-026 SS_n rise mid-frame SHALL abort: no write, no INT clear, bit_cnt cleared at next SS_n fall.

Reset
REQ-027 On rst_n low: MISO=0, INT=0, INT1_CTRL/CTRL1_XL/CTRL2_G=8'h00, data registers=8'h00, sample_idx=0, timer=0, pending=0, shifters and bit_cnt=0.
REQ-028 Synchronizer flops for SS_n and SCLK SHALL reset to 1, MOSI to 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; first frame after release starts clean at next SS_n fall.

Verification
REQ-030 Read frame 16'h8F00 -> MISO bits 8-15 = 8'h6A; INT stays 0.
REQ-031 Write 16'h0D02, then read 16'h8D00 -> returns 8'h02; after 1024 clk INT=1 and read 16'hA200 returns 8'h00, 16'hA300 returns 8'h01 (sample_idx 1, k 0).
REQ-032 INT=1, read 16'hAD00 complete -> INT 0 within 3 clk of SS_n rise; 16'hA800 returns 8'h03.
REQ-033 SAMPLE_PERIOD expires while SS_n held low -> data unchanged until SS_n rise, then updates next cycle; INT=1.
REQ-034 Write 16'h1055 with SS_n raised after 10 bits -> CTRL1_XL remains 8'h00; following read 16'h9000 returns 8'h00.
REQ-035 Assert rst_n low mid-read with INT=1 -> INT=0, MISO=0, INT1_CTRL=0 immediately; no sample events afterwards.
